// File: rtl/audio_sample_dac.sv
// ---------------------------------------------------------------------------
// audio_sample_dac
//
// Memory-mapped audio output stage. The CPU writes signed 16-bit PCM samples
// into a FIFO; a programmable sample timer pops one sample per period into
// cur_sample, and a first-order sigma-delta modulator turns cur_sample into a
// 1-bit pulse-density stream on dsd.
//
// Register map (addr[3:2]):
//   0 DATA   W: push wdata[15:0] (stalls while FIFO full); R: 0
//   1 STATUS R: [7:0] level, [16] underrun (sticky), [17] empty, [18] full
//            W: wstrb[2] && wdata[16] clears underrun
//   2 DIV    R/W: [15:0] clk cycles per sample, values < 2 stored as 2
//   3 reserved: reads 0, writes ignored
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   reset  in   synchronous active-high reset
//   sel    in   bus request (decoded iomem_valid), held until ready
//   wstrb  in   byte write strobes, 0 = read
//   addr   in   byte address within window, only [3:2] decoded
//   wdata  in   write data
//   rdata  out  read data, valid while ready = 1
//   ready  out  one-cycle registered acknowledge
//   dsd    out  registered pulse-density output
// ---------------------------------------------------------------------------
module audio_sample_dac #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 523
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  wstrb,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        dsd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RST    = 16'(DEFAULT_DIV);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // FIFO storage and state
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  // Timer, modulator and control state
  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [15:0] cur_sample;
  logic [15:0] acc;
  logic        underrun;

  logic        empty;
  logic        full;
  logic        tick;
  logic        pop;
  logic        access;
  logic        is_write;
  logic [1:0]  reg_idx;
  logic        data_write;
  logic        push;
  logic        ack;
  logic [15:0] lane_data;
  logic [15:0] div_merge;
  logic [15:0] div_next;
  logic [31:0] rd_mux;
  logic [15:0] u;
  logic [16:0] sum;

  assign empty = (level == '0);
  assign full  = (level == LEVEL_FULL);

  // Sample timer: tick on the cycle the down-counter sits at zero.
  assign tick = (cnt_q == 16'd0);
  assign pop  = tick && !empty;

  // Handshake: a request is live while sel=1 and ready=0. The cycle ready=1
  // is the acknowledge; the requester drops sel (or starts a new access)
  // afterwards, so gating with !ready prevents a second ack for the same
  // access. A DATA write to a full FIFO is only accepted on a pop cycle,
  // so the push and the ack land on the same clock edge.
  assign access     = sel && !ready;
  assign is_write   = (wstrb != 4'b0000);
  assign reg_idx    = addr[3:2];
  assign data_write = access && is_write && (reg_idx == REG_DATA);
  assign push       = data_write && (!full || pop);
  assign ack        = access && !(data_write && full && !pop);

  // Only enabled byte lanes contribute write data.
  assign lane_data = {wstrb[1] ? wdata[15:8] : 8'h00,
                      wstrb[0] ? wdata[7:0]  : 8'h00};
  assign div_merge = {wstrb[1] ? wdata[15:8] : div_q[15:8],
                      wstrb[0] ? wdata[7:0]  : div_q[7:0]};
  assign div_next  = (div_merge < 16'd2) ? 16'd2 : div_merge;

  always_comb begin
    rd_mux = 32'h0;
    case (reg_idx)
      REG_STATUS: rd_mux = {13'h0, full, empty, underrun, 8'h00, 8'(level)};
      REG_DIV:    rd_mux = {16'h0, div_q};
      default:    rd_mux = 32'h0;
    endcase
  end

  // Offset-binary sample; the carry of the accumulator is the density bit.
  assign u   = cur_sample ^ 16'h8000;
  assign sum = {1'b0, acc} + {1'b0, u};

  // Sample storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= lane_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      div_q      <= DIV_RST;
      cnt_q      <= DIV_RST - 16'd1;
      cur_sample <= 16'h0000;
      acc        <= 16'h0000;
      underrun   <= 1'b0;
      ready      <= 1'b0;
      rdata      <= 32'h0;
      dsd        <= 1'b0;
    end else begin
      // Bus acknowledge and read data
      ready <= ack;
      rdata <= (ack && !is_write) ? rd_mux : 32'h0;

      // FIFO pointers and level
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        cur_sample <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Timer reload picks up DIV only at the period boundary.
      if (tick) begin
        cnt_q <= div_q - 16'd1;
      end else begin
        cnt_q <= cnt_q - 16'd1;
      end

      if (ack && is_write && (reg_idx == REG_DIV)) begin
        div_q <= div_next;
      end

      // A fresh underrun event wins over a simultaneous clear.
      if (tick && empty) begin
        underrun <= 1'b1;
      end else if (ack && (reg_idx == REG_STATUS) && wstrb[2] && wdata[16]) begin
        underrun <= 1'b0;
      end

      // Modulator
      acc <= sum[15:0];
      dsd <= sum[16];
    end
  end

endmodule

// File: doc/audio_sample_dac.md
Name: audio_sample_dac

Overview:
- Memory-mapped audio output stage on the SoC iomem bus, decoded by the top level in the 0x04xx_xxxx window.
- Buffers signed 16-bit PCM samples written by the CPU in a FIFO.
- Pops one sample per programmable sample period.
- Converts the current sample to a 1-bit pulse-density (DSD) stream with a first-order sigma-delta modulator that drives the audio pin.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 523, reset value of the DIV register (clk cycles per sample; 25.125 MHz / 48 kHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  bus request: iomem_valid qualified by the top-level address decode. Held until ready.
- wstrb  in  4  byte write strobes; 0 means read.
- addr  in  24  byte address within window; only addr[3:2] decoded.
- wdata  in  32  write data.
- rdata  out  32  read data; valid while ready=1.
- ready  out  1  one-cycle acknowledge.
- dsd  out  1  registered pulse-density output.

Behaviour:
Reset:
- Reset is synchronous, active-high, on clk. It clears the FIFO (level 0), ready=0, rdata=0, dsd=0, accumulator=0, cur_sample=0, underrun=0.
- DIV=DEFAULT_DIV and the sample counter is loaded with DIV-1.
- Reset mid-transaction drops any pending or stalled access without an acknowledge.

Bus:
- ready is registered and asserted for exactly one cycle. It is never asserted on a cycle where ready was already 1, so there is no double-ack.
- Normal latency is 1 cycle after sel is seen.
- A write is any access with wstrb != 0. Registers take data only from enabled byte lanes.

Registers (addr[3:2]):
- 0 DATA
  - Write pushes wdata[15:0] as a signed sample.
  - If the FIFO is full, ready is withheld (CPU stalls) until a pop frees an entry. The push and the ack then occur on the same cycle.
  - Read returns 0 with no stall.
- 1 STATUS (R)
  - [7:0] level (0..FIFO_DEPTH).
  - [16] underrun, sticky.
  - [17] empty.
  - [18] full.
  - Other bits are 0.
  - A write with wstrb[2]=1 and wdata[16]=1 clears underrun; all other write bits are ignored.
- 2 DIV (R/W)
  - [15:0] clk cycles per sample; other bits read 0.
  - Written values below 2 are stored as 2.
  - A new DIV takes effect at the next counter reload, not mid-period.
- 3 reserved: reads 0, writes ignored, acked normally.

Sample timer:
- Down-counter. When it reaches 0, it reloads DIV-1 and issues a one-cycle tick.
- On tick with FIFO not empty: pop the oldest entry into cur_sample.
- On tick with FIFO empty: cur_sample holds its value and underrun is set.
- Push and pop on the same cycle are both performed and the level is unchanged.
- When full, a pop frees an entry the same cycle, which allows the stalled push.

Modulator (every clk):
- u = cur_sample XOR 0x8000, i.e. offset-binary 0..65535.
- {carry, acc[15:0]} = acc + u (17-bit sum).
- dsd <= carry.
- Ones density is exactly u/65536 over any 65536-cycle window with a constant sample.

Test Plan:
1. Reset, then:
   - read STATUS -> 0x0002_0000.
   - read DIV -> 523 (0x20B).
   - dsd=0 and ready=0 during reset.
   - each access acked exactly 1 cycle after sel.
2. Write DIV=4, push 0x0000, then wait one tick:
   - dsd is a strict 1,0,1,0 alternation: u=0x8000, acc toggles 0x8000/0x0000.
   - Over 1024 cycles: exactly 512 ones.
3. Density extremes:
   - push 0x8000 -> dsd constantly 0.
   - push 0x7FFF -> exactly 65535 ones in 65536 cycles.
4. Full and stall (DIV=0xFFFF):
   - 16 pushes acked at 1-cycle latency; STATUS level 16, full=1.
   - 17th push: ready stays low until the next tick, then acks on the pop cycle; level stays 16.
5. Underrun (DIV=8):
   - push 0x1234, wait 3 ticks -> STATUS[16]=1, empty=1, cur_sample still 0x1234.
   - write STATUS with wdata=0x0001_0000, wstrb=4'b0100 -> STATUS[16]=0.
6. Reset mid-operation:
   - assert reset with level 5 and a push stalled on full -> next cycle level 0, ready 0, dsd 0, DIV=523.
   - the stalled push is not acked.
